// File: rtl/f_ifu.sv
// f_ifu: fetch-stage PC holder and instruction-memory request/grant/response sequencer
// Ports:
//   clk_i          clock, all state updates on rising edge
//   rst_ni         asynchronous active-low reset
//   stall_i        decode cannot accept the presented instruction this cycle
//   npc_i          next fetch address from decode, loaded on an accepted handoff
//   imem_req_o     fetch request to instruction memory
//   imem_addr_o    request address (always the current fetch PC)
//   imem_gnt_i     memory accepted the request this cycle
//   imem_rvalid_i  read data valid this cycle
//   imem_rdata_i   instruction word from memory
//   f_pc_o         PC of the instruction being fetched/presented
//   f_instr_o      instruction to the F/D register (zero when not valid)
//   f_valid_o      f_instr_o/f_pc_o valid for decode this cycle
//   f_exc_adel_o   address error on fetch, accompanies f_valid_o
module f_ifu #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] PC_MIN   = 32'h0000_3000,
    parameter logic [31:0] PC_MAX   = 32'h0000_6ffc
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic [31:0] npc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] f_pc_o,
    output logic [31:0] f_instr_o,
    output logic        f_valid_o,
    output logic        f_exc_adel_o
);
    typedef enum logic [1:0] {REQ, RESP, HAVE} state_e;
    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] buf_q;
    logic        exc_q;
    logic        pc_ok;
    logic        resp_hit;
    assign pc_ok    = (pc_q[1:0] == 2'b00) && (pc_q >= PC_MIN) && (pc_q <= PC_MAX);
    // responses are only meaningful while a granted request is outstanding
    assign resp_hit = (state_q == RESP) && imem_rvalid_i;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= REQ;
            pc_q    <= PC_RESET;
            buf_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            case (state_q)
                REQ: begin
                    if (!pc_ok) begin
                        state_q <= HAVE;
                        buf_q   <= '0;
                        exc_q   <= 1'b1;
                    end else if (imem_gnt_i) begin
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (imem_rvalid_i) begin
                        if (stall_i) begin
                            state_q <= HAVE;
                            buf_q   <= imem_rdata_i;
                            exc_q   <= 1'b0;
                        end else begin
                            state_q <= REQ;
                            pc_q    <= npc_i;
                        end
                    end
                end
                HAVE: begin
                    if (!stall_i) begin
                        state_q <= REQ;
                        pc_q    <= npc_i;
                        buf_q   <= '0;
                        exc_q   <= 1'b0;
                    end
                end
                default: state_q <= REQ;
            endcase
        end
    end
    // the reset state is REQ, so the request is gated to stay quiet while reset is held
    assign imem_req_o   = rst_ni && (state_q == REQ) && pc_ok;
    assign imem_addr_o  = pc_q;
    assign f_pc_o       = pc_q;
    assign f_valid_o    = (state_q == HAVE) || resp_hit;
    assign f_instr_o    = (state_q == HAVE) ? buf_q : resp_hit ? imem_rdata_i : '0;
    assign f_exc_adel_o = (state_q == HAVE) && exc_q;
endmodule

// File: tb/tb_f_ifu.sv
// tb_f_ifu: directed self-checking bench for the fetch unit
module tb_f_ifu;
    logic        clk, rst_n, stall, gnt, rvalid;
    logic [31:0] npc, rdata;
    logic        req, valid, exc;
    logic [31:0] addr, pc, instr;
    int tests, fails;

    f_ifu dut (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall), .npc_i(npc),
        .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .f_pc_o(pc), .f_instr_o(instr), .f_valid_o(valid), .f_exc_adel_o(exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        cyc();
        rst_n = 1'b0; gnt = 1'b0; rvalid = 1'b0; stall = 1'b0; rdata = '0; npc = 32'h3004;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; gnt = 1'b1; rvalid = 1'b1; stall = 1'b0; rdata = 32'hdead_beef; npc = 32'h3004;
        #12;
        tests++;
        if ({req, valid, exc, instr, pc} !== {1'b0, 1'b0, 1'b0, 32'h0, 32'h3000}) begin
            fails++;
            $display("FAIL reset_state: req/valid/exc/instr/pc=%b/%b/%b/%h/%h want 0/0/0/0/00003000", req, valid, exc, instr, pc);
        end
        gnt = 1'b0; rvalid = 1'b0;
    endtask

    task automatic test_basic();
        reset_dut();
        gnt = 1'b1; npc = 32'h3004;
        #1;
        tests++;
        if ({req, addr, valid} !== {1'b1, 32'h3000, 1'b0}) begin
            fails++;
            $display("FAIL basic_req: req/addr/valid=%b/%h/%b want 1/00003000/0", req, addr, valid);
        end
        cyc();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h3c01_1234;
        #1;
        tests++;
        if ({req, valid, exc, pc, instr} !== {1'b0, 1'b1, 1'b0, 32'h3000, 32'h3c01_1234}) begin
            fails++;
            $display("FAIL basic_resp: req/valid/exc/pc/instr=%b/%b/%b/%h/%h want 0/1/0/00003000/3c011234", req, valid, exc, pc, instr);
        end
        cyc();
        rvalid = 1'b0;
        #1;
        tests++;
        if ({req, addr, valid, instr} !== {1'b1, 32'h3004, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL basic_next: req/addr/valid/instr=%b/%h/%b/%h want 1/00003004/0/0", req, addr, valid, instr);
        end
    endtask

    task automatic test_gnt_wait();
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            npc = 32'h3100 + 32'(i * 4);
            gnt = (i == 3);
            #1;
            tests++;
            if ({req, addr, valid} !== {1'b1, 32'h3000, 1'b0}) begin
                fails++;
                $display("FAIL gnt_wait[%0d]: req/addr/valid=%b/%h/%b want 1/00003000/0", i, req, addr, valid);
            end
            cyc();
        end
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678; npc = 32'h3008;
        #1;
        tests++;
        if ({valid, instr, pc} !== {1'b1, 32'h1234_5678, 32'h3000}) begin
            fails++;
            $display("FAIL gnt_wait_resp: valid/instr/pc=%b/%h/%h want 1/12345678/00003000", valid, instr, pc);
        end
        cyc();
        rvalid = 1'b0;
        #1;
        tests++;
        if ({req, addr} !== {1'b1, 32'h3008}) begin
            fails++;
            $display("FAIL gnt_wait_next: req/addr=%b/%h want 1/00003008", req, addr);
        end
    endtask

    task automatic test_stall();
        reset_dut();
        gnt = 1'b1;
        cyc();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'hAAAA_5555; stall = 1'b1; npc = 32'h3004;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if ({valid, instr, exc, pc, req} !== {1'b1, 32'hAAAA_5555, 1'b0, 32'h3000, 1'b0}) begin
                fails++;
                $display("FAIL stall_hold[%0d]: valid/instr/exc/pc/req=%b/%h/%b/%h/%b want 1/aaaa5555/0/00003000/0", i, valid, instr, exc, pc, req);
            end
            cyc();
            rvalid = 1'b0; rdata = 32'h0bad_0bad; gnt = 1'b1;
            stall = (i == 0);
        end
        gnt = 1'b0;
        #1;
        tests++;
        if ({req, addr, pc, valid} !== {1'b1, 32'h3004, 32'h3004, 1'b0}) begin
            fails++;
            $display("FAIL stall_release: req/addr/pc/valid=%b/%h/%h/%b want 1/00003004/00003004/0", req, addr, pc, valid);
        end
    endtask

    task automatic test_adel();
        reset_dut();
        gnt = 1'b1; npc = 32'h3002;
        cyc();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0000_1111;
        cyc();
        rvalid = 1'b0; gnt = 1'b1; stall = 1'b1;
        #1;
        tests++;
        if ({req, valid, exc} !== 3'b000) begin
            fails++;
            $display("FAIL adel_misalign_req: req/valid/exc=%b/%b/%b want 0/0/0", req, valid, exc);
        end
        cyc();
        gnt = 1'b0; stall = 1'b0; npc = 32'h7000;
        #1;
        tests++;
        if ({valid, exc, instr, pc, req} !== {1'b1, 1'b1, 32'h0, 32'h3002, 1'b0}) begin
            fails++;
            $display("FAIL adel_misalign: valid/exc/instr/pc/req=%b/%b/%h/%h/%b want 1/1/0/00003002/0", valid, exc, instr, pc, req);
        end
        cyc();
        #1;
        tests++;
        if ({req, valid, pc} !== {1'b0, 1'b0, 32'h7000}) begin
            fails++;
            $display("FAIL adel_range_req: req/valid/pc=%b/%b/%h want 0/0/00007000", req, valid, pc);
        end
        cyc();
        npc = 32'h6ffc;
        #1;
        tests++;
        if ({valid, exc, instr, pc} !== {1'b1, 1'b1, 32'h0, 32'h7000}) begin
            fails++;
            $display("FAIL adel_range: valid/exc/instr/pc=%b/%b/%h/%h want 1/1/0/00007000", valid, exc, instr, pc);
        end
        cyc();
        #1;
        tests++;
        if ({req, addr, valid, exc} !== {1'b1, 32'h6ffc, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL adel_max_legal: req/addr/valid/exc=%b/%h/%b/%b want 1/00006ffc/0/0", req, addr, valid, exc);
        end
    endtask

    task automatic test_reset_mid_resp();
        reset_dut();
        gnt = 1'b1; npc = 32'h3004;
        cyc();
        gnt = 1'b0;
        #1;
        tests++;
        if ({req, valid} !== 2'b00) begin
            fails++;
            $display("FAIL mid_resp_wait: req/valid=%b/%b want 0/0", req, valid);
        end
        #2;
        rst_n = 1'b0; rvalid = 1'b1; rdata = 32'hdead_beef;
        #1;
        tests++;
        if ({req, valid, exc, instr, pc} !== {1'b0, 1'b0, 1'b0, 32'h0, 32'h3000}) begin
            fails++;
            $display("FAIL mid_resp_reset: req/valid/exc/instr/pc=%b/%b/%b/%h/%h want 0/0/0/0/00003000", req, valid, exc, instr, pc);
        end
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        tests++;
        if ({req, addr, valid, instr} !== {1'b1, 32'h3000, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL stale_ignored: req/addr/valid/instr=%b/%h/%b/%h want 1/00003000/0/0", req, addr, valid, instr);
        end
        cyc();
        gnt = 1'b1;
        #1;
        tests++;
        if ({req, valid} !== 2'b10) begin
            fails++;
            $display("FAIL stale_with_gnt: req/valid=%b/%b want 1/0", req, valid);
        end
        cyc();
        gnt = 1'b0; rdata = 32'h3c01_1234;
        #1;
        tests++;
        if ({valid, instr, pc} !== {1'b1, 32'h3c01_1234, 32'h3000}) begin
            fails++;
            $display("FAIL restart_resp: valid/instr/pc=%b/%h/%h want 1/3c011234/00003000", valid, instr, pc);
        end
        cyc();
        rvalid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] nseq [3] = '{32'h3010, 32'h3000, 32'h3004};
        logic [31:0] aseq [3] = '{32'h3000, 32'h3010, 32'h3000};
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            gnt = 1'b1; rvalid = 1'b0; npc = nseq[i];
            #1;
            tests++;
            if ({req, addr, valid} !== {1'b1, aseq[i], 1'b0}) begin
                fails++;
                $display("FAIL b2b_req[%0d]: req/addr/valid=%b/%h/%b want 1/%h/0", i, req, addr, valid, aseq[i]);
            end
            cyc();
            gnt = 1'b0; rvalid = 1'b1; rdata = 32'hc0de_0000 + 32'(i);
            #1;
            tests++;
            if ({req, valid, pc, instr} !== {1'b0, 1'b1, aseq[i], 32'hc0de_0000 + 32'(i)}) begin
                fails++;
                $display("FAIL b2b_resp[%0d]: req/valid/pc/instr=%b/%b/%h/%h want 0/1/%h/%h", i, req, valid, pc, instr, aseq[i], 32'hc0de_0000 + 32'(i));
            end
            cyc();
        end
        rvalid = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_gnt_wait();
        test_stall();
        test_adel();
        test_reset_mid_resp();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
